// File: rtl/uart_pkg.sv
// Shared constants for the UART receive controller: FSM encoding and prescale values.
package uart_pkg;

    localparam logic [1:0] ST_DISABLED  = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_CFG_WAIT  = 2'd2;
    localparam logic [1:0] ST_CFG_APPLY = 2'd3;

    localparam logic [5:0] PRESCALE_8     = 6'd8;
    localparam logic [5:0] PRESCALE_16    = 6'd16;
    localparam logic [5:0] PRESCALE_32    = 6'd32;
    localparam logic [5:0] PRESCALE_RESET = PRESCALE_8;

    function automatic logic prescale_legal(input logic [5:0] ps);
        return (ps == PRESCALE_8) || (ps == PRESCALE_16) || (ps == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// RX-core and host-read signal bundle; master is the controller side.
interface uart_rx_ctrl_if #(
    parameter int DW = 8
);
    logic          rx_en;
    logic [5:0]    rx_prescale;
    logic          rx_par_en;
    logic          rx_busy;
    logic          rx_data_valid;
    logic [DW-1:0] rx_p_data;
    logic          rx_frame_err;
    logic          host_valid;
    logic [DW-1:0] host_data;
    logic          host_ready;

    modport master (
        output rx_en, rx_prescale, rx_par_en, host_valid, host_data,
        input  rx_busy, rx_data_valid, rx_p_data, rx_frame_err, host_ready
    );

    modport slave (
        input  rx_en, rx_prescale, rx_par_en, host_valid, host_data,
        output rx_busy, rx_data_valid, rx_p_data, rx_frame_err, host_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive buffer: power-of-two circular FIFO, head readable combinationally.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DW-1:0]           push_data,
    input  logic                    pop,
    output logic [DW-1:0]           pop_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign empty    = (fill == '0);
    assign full     = (fill == FILL_MAX);
    assign do_pop   = pop && !empty;
    // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      fill <= fill + FILL_ONE;
            else if (!do_push && do_pop) fill <= fill - FILL_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: safe runtime reconfiguration of the RX core,
// receive buffering toward the host, and overrun / frame-error status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    enable,
    input  logic                    cfg_wr,
    input  logic [5:0]              cfg_prescale,
    input  logic                    cfg_par_en,
    output logic                    cfg_ack,
    output logic                    cfg_err,
    input  logic                    ovr_clr,
    output logic                    overrun,
    output logic [7:0]              err_cnt,
    output logic [$clog2(DEPTH):0]  fill,
    uart_rx_ctrl_if.master          bus
);
    logic [1:0]    state, state_nxt;
    logic [5:0]    pend_ps, pend_ps_nxt, act_ps;
    logic          pend_par, pend_par_nxt, act_par;
    logic          pend_req, cfg_legal, req_any;
    logic          fifo_full, fifo_empty, pop;
    logic [DW-1:0] head;

    assign cfg_legal    = cfg_wr && prescale_legal(cfg_prescale);
    assign req_any      = cfg_legal || pend_req;
    assign pend_ps_nxt  = cfg_legal ? cfg_prescale : pend_ps;
    assign pend_par_nxt = cfg_legal ? cfg_par_en   : pend_par;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DISABLED:  if (req_any) state_nxt = ST_CFG_APPLY;
                          else if (enable) state_nxt = ST_RUN;
            ST_RUN:       if (!enable) state_nxt = ST_DISABLED;
                          else if (req_any) state_nxt = ST_CFG_WAIT;
            // Wait for the core to go idle so a frame is never cut short.
            ST_CFG_WAIT:  if (!enable || !bus.rx_busy) state_nxt = ST_CFG_APPLY;
            ST_CFG_APPLY: state_nxt = enable ? ST_RUN : ST_DISABLED;
            default:      state_nxt = ST_DISABLED;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_DISABLED;
            pend_ps  <= PRESCALE_RESET;
            pend_par <= 1'b0;
            pend_req <= 1'b0;
            act_ps   <= PRESCALE_RESET;
            act_par  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pend_ps  <= pend_ps_nxt;
            pend_par <= pend_par_nxt;
            cfg_err  <= cfg_wr && !cfg_legal;
            // Entering APPLY consumes the request, including one arriving this cycle.
            if (state_nxt == ST_CFG_APPLY) begin
                pend_req <= 1'b0;
                act_ps   <= pend_ps_nxt;
                act_par  <= pend_par_nxt;
            end else if (cfg_legal) begin
                pend_req <= 1'b1;
            end
        end
    end

    assign cfg_ack         = (state == ST_CFG_APPLY);
    assign bus.rx_en       = (state == ST_RUN) || (state == ST_CFG_WAIT);
    assign bus.rx_prescale = act_ps;
    assign bus.rx_par_en   = act_par;

    assign pop            = !fifo_empty && bus.host_ready;
    assign bus.host_valid = !fifo_empty;
    assign bus.host_data  = head;

    uart_rx_fifo #(.DEPTH(DEPTH), .DW(DW)) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .push      (bus.rx_data_valid),
        .push_data (bus.rx_p_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .fill      (fill)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overrun <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            if (bus.rx_data_valid && fifo_full && !pop) overrun <= 1'b1;
            else if (ovr_clr)                           overrun <= 1'b0;
            if (bus.rx_frame_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH=4, DW=8) with hand-computed expectations.
module tb_uart_rx_ctrl;
    logic       clk;
    logic       rst;
    logic       enable;
    logic       cfg_wr;
    logic [5:0] cfg_prescale;
    logic       cfg_par_en;
    logic       cfg_ack;
    logic       cfg_err;
    logic       ovr_clr;
    logic       overrun;
    logic [7:0] err_cnt;
    logic [2:0] fill;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_ctrl_if #(.DW(8)) bus ();

    uart_rx_ctrl #(.DEPTH(4), .DW(8)) dut (
        .CLK          (clk),
        .RST          (rst),
        .enable       (enable),
        .cfg_wr       (cfg_wr),
        .cfg_prescale (cfg_prescale),
        .cfg_par_en   (cfg_par_en),
        .cfg_ack      (cfg_ack),
        .cfg_err      (cfg_err),
        .ovr_clr      (ovr_clr),
        .overrun      (overrun),
        .err_cnt      (err_cnt),
        .fill         (fill),
        .bus          (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 0; cfg_wr = 0; cfg_prescale = 6'd0; cfg_par_en = 0; ovr_clr = 0;
        bus.rx_busy = 0; bus.rx_data_valid = 0; bus.rx_p_data = 8'h00;
        bus.rx_frame_err = 0; bus.host_ready = 0;
        #1 rst = 1'b0;
        #2;
        check("rst_rx_en",      {31'd0, bus.rx_en}, 0);
        check("rst_prescale",   {26'd0, bus.rx_prescale}, 8);
        check("rst_par_en",     {31'd0, bus.rx_par_en}, 0);
        check("rst_cfg_ack",    {31'd0, cfg_ack}, 0);
        check("rst_cfg_err",    {31'd0, cfg_err}, 0);
        check("rst_fill",       {29'd0, fill}, 0);
        check("rst_host_valid", {31'd0, bus.host_valid}, 0);
        check("rst_overrun",    {31'd0, overrun}, 0);
        check("rst_err_cnt",    {24'd0, err_cnt}, 0);
        step(); step();
        rst = 1'b1;
        step();
        check("disabled_rx_en", {31'd0, bus.rx_en}, 0);

        // Basic receive path
        enable = 1; step();
        check("run_rx_en", {31'd0, bus.rx_en}, 1);
        bus.host_ready = 1;
        bus.rx_data_valid = 1; bus.rx_p_data = 8'hA5; step();
        check("rx1_valid", {31'd0, bus.host_valid}, 1);
        check("rx1_data",  {24'd0, bus.host_data}, 32'hA5);
        bus.rx_p_data = 8'h3C; step();
        bus.rx_data_valid = 0;
        check("rx2_valid", {31'd0, bus.host_valid}, 1);
        check("rx2_data",  {24'd0, bus.host_data}, 32'h3C);
        step();
        check("rx_drained", {31'd0, bus.host_valid}, 0);

        // Empty push+pop: no fall-through
        bus.rx_data_valid = 1; bus.rx_p_data = 8'h77; step();
        bus.rx_data_valid = 0;
        check("nofall_fill", {29'd0, fill}, 1);
        check("nofall_data", {24'd0, bus.host_data}, 32'h77);
        step();
        check("nofall_pop", {31'd0, bus.host_valid}, 0);

        // Overrun, with set winning over a simultaneous clear
        bus.host_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            bus.rx_data_valid = 1; bus.rx_p_data = 8'(i); ovr_clr = (i == 5);
            step();
        end
        bus.rx_data_valid = 0; ovr_clr = 0;
        check("ovr_fill",     {29'd0, fill}, 4);
        check("ovr_set_wins", {31'd0, overrun}, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_pop_data", {24'd0, bus.host_data}, i);
            bus.host_ready = 1; step(); bus.host_ready = 0;
        end
        check("ovr_empty",  {29'd0, fill}, 0);
        check("ovr_sticky", {31'd0, overrun}, 1);
        ovr_clr = 1; step(); ovr_clr = 0;
        check("ovr_cleared", {31'd0, overrun}, 0);

        // Full FIFO, push and pop together
        for (int i = 0; i < 4; i++) begin
            bus.rx_data_valid = 1; bus.rx_p_data = 8'h10 + 8'(i); step();
        end
        check("full_fill", {29'd0, fill}, 4);
        bus.rx_p_data = 8'h14; bus.host_ready = 1; step();
        bus.rx_data_valid = 0; bus.host_ready = 0;
        check("pp_fill",    {29'd0, fill}, 4);
        check("pp_overrun", {31'd0, overrun}, 0);
        check("pp_head",    {24'd0, bus.host_data}, 32'h11);
        for (int i = 0; i < 4; i++) begin
            check("pp_drain", {24'd0, bus.host_data}, 32'h11 + i);
            bus.host_ready = 1; step(); bus.host_ready = 0;
        end
        check("pp_empty", {29'd0, fill}, 0);

        // Reconfiguration deferred until the core is idle
        bus.rx_busy = 1;
        cfg_wr = 1; cfg_prescale = 6'd16; cfg_par_en = 1; step();
        cfg_wr = 0;
        check("wait_rx_en",  {31'd0, bus.rx_en}, 1);
        check("wait_ps",     {26'd0, bus.rx_prescale}, 8);
        step();
        check("wait_ps2",    {26'd0, bus.rx_prescale}, 8);
        check("wait_no_ack", {31'd0, cfg_ack}, 0);
        bus.rx_busy = 0; step();
        check("apply_rx_en", {31'd0, bus.rx_en}, 0);
        check("apply_ack",   {31'd0, cfg_ack}, 1);
        check("apply_ps",    {26'd0, bus.rx_prescale}, 16);
        check("apply_par",   {31'd0, bus.rx_par_en}, 1);
        step();
        check("back_run",    {31'd0, bus.rx_en}, 1);
        check("ack_single",  {31'd0, cfg_ack}, 0);

        // Illegal prescale
        cfg_wr = 1; cfg_prescale = 6'd12; cfg_par_en = 0; step();
        cfg_wr = 0;
        check("ill_err",   {31'd0, cfg_err}, 1);
        check("ill_ack",   {31'd0, cfg_ack}, 0);
        check("ill_ps",    {26'd0, bus.rx_prescale}, 16);
        check("ill_rx_en", {31'd0, bus.rx_en}, 1);
        step();
        check("ill_err_pulse", {31'd0, cfg_err}, 0);
        check("ill_no_ack",    {31'd0, cfg_ack}, 0);

        // Second write in CFG_WAIT overrides the first
        bus.rx_busy = 1;
        cfg_wr = 1; cfg_prescale = 6'd32; cfg_par_en = 1; step();
        cfg_prescale = 6'd8; cfg_par_en = 0; step();
        cfg_wr = 0;
        check("ovw_ps_hold", {26'd0, bus.rx_prescale}, 16);
        bus.rx_busy = 0; step();
        check("ovw_ack", {31'd0, cfg_ack}, 1);
        check("ovw_ps",  {26'd0, bus.rx_prescale}, 8);
        check("ovw_par", {31'd0, bus.rx_par_en}, 0);
        step();
        check("ovw_one_ack", {31'd0, cfg_ack}, 0);

        // Disable while waiting: apply then DISABLED
        bus.rx_busy = 1;
        cfg_wr = 1; cfg_prescale = 6'd32; step();
        cfg_wr = 0; enable = 0; step();
        check("dw_apply_ack", {31'd0, cfg_ack}, 1);
        check("dw_apply_ps",  {26'd0, bus.rx_prescale}, 32);
        check("dw_rx_en",     {31'd0, bus.rx_en}, 0);
        step();
        check("dw_dis_ack",   {31'd0, cfg_ack}, 0);
        check("dw_dis_rx_en", {31'd0, bus.rx_en}, 0);

        // Configure while disabled
        bus.rx_busy = 0;
        cfg_wr = 1; cfg_prescale = 6'd16; step();
        cfg_wr = 0;
        check("dis_cfg_ack", {31'd0, cfg_ack}, 1);
        check("dis_cfg_ps",  {26'd0, bus.rx_prescale}, 16);
        step();
        check("dis_cfg_back", {31'd0, bus.rx_en}, 0);
        enable = 1; step();
        check("dis_to_run", {31'd0, bus.rx_en}, 1);
        bus.rx_busy = 1; enable = 0; step();
        check("run_abort", {31'd0, bus.rx_en}, 0);
        bus.rx_busy = 0; enable = 1; step();

        // Frame-error counter, reset mid-sequence, saturation
        bus.rx_frame_err = 1;
        repeat (100) step();
        check("err_100", {24'd0, err_cnt}, 100);
        check("err_run", {31'd0, bus.rx_en}, 1);
        rst = 0; #1;
        check("mid_rst_err",   {24'd0, err_cnt}, 0);
        check("mid_rst_rx_en", {31'd0, bus.rx_en}, 0);
        check("mid_rst_ps",    {26'd0, bus.rx_prescale}, 8);
        step();
        rst = 1; #1;
        check("post_rst_rx_en", {31'd0, bus.rx_en}, 0);
        repeat (300) step();
        bus.rx_frame_err = 0;
        check("err_sat", {24'd0, err_cnt}, 255);
        step();
        check("err_hold", {24'd0, err_cnt}, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
